// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment scan controller and its decoder:
//   the scan FSM state type and the active-low segment patterns.
//   Segment vectors are declared [0:6] so that bit 0 is segment a and bit 6
//   is segment g; a literal such as 7'b0000001 therefore reads a..g from
//   left to right.
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // All segments off (active-low) and the dash shown for non-BCD codes.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;

  // Digit patterns, segments a..g, active-low.
  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b1100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0001100;

endpackage : seg7_pkg

// File: rtl/bcd_7seg.sv
// -----------------------------------------------------------------------------
// bcd_7seg
//   Purely combinational BCD to 7-segment decoder, active-low segments.
//   Codes 10..15 are not valid BCD and display a dash.
//
//   Ports:
//     bcd_i  in   4  BCD code
//     seg_o  out  7  segments a..g ([0] = a), active-low
// -----------------------------------------------------------------------------
module bcd_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [0:6] seg_o
);

  always_comb begin
    // NOTE: combinational outputs get a default before the case so that no
    // path leaves seg_o unassigned; otherwise synthesis infers a latch.
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule : bcd_7seg

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a common-anode multi-digit 7-segment
//   display. Digits are lit one at a time in order 0..NUM_DIGITS-1, each for
//   ON_CYCLES clocks followed by GAP_CYCLES clocks with every anode off to
//   suppress ghosting. New data is parked in a pending register and copied to
//   the displayed register only at a frame boundary (or straight away from
//   IDLE), so one frame never mixes old and new digits.
//
//   Parameters:
//     NUM_DIGITS  digits scanned (2..8)
//     ON_CYCLES   clocks each digit is lit per slot (>= 1)
//     GAP_CYCLES  all-off clocks after each lit slot (>= 1)
//
//   Ports:
//     clk      in   1             clock, rising edge
//     rst_n    in   1             synchronous active-low reset
//     load     in   1             new-data request, taken when load && ready
//     data_in  in   4*NUM_DIGITS  BCD digits, digit k = data_in[4k+3:4k]
//     lz_en    in   1             leading-zero suppression, sampled with data_in
//     ready    out  1             pending slot free, load will be accepted
//     seg      out  7             segments a..g ([0] = a), active-low, registered
//     an       out  NUM_DIGITS    anodes, active-low, registered, one-cold or all 1
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ON_CYCLES  = 1000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_en,
  output logic                    ready,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned MAX_PH = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_PH + 1);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_W-1:0]     pend_data_q, pend_data_d;
  logic                  pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [DATA_W-1:0]     disp_data_q, disp_data_d;
  logic                  disp_lz_q, disp_lz_d;

  logic [0:6]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // ---------------------------------------------------------------------------
  // Digit selection, leading-zero detection and decode
  // ---------------------------------------------------------------------------
  logic [3:0]            digit_sel;
  logic [0:6]            digit_seg;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  digit_blank;
  logic                  accept;

  always_comb begin
    digit_sel = disp_data_q[4*idx_q +: 4];
  end

  // lead_zero[k] is set when digit k and every digit above it are zero, i.e.
  // digit k is still inside the run of leading zeros.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (disp_data_q[DATA_W-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (disp_data_q[4*k +: 4] == 4'd0);
    end
  end

  // Digit 0 always lights so that a value of zero still shows "0".
  assign digit_blank = disp_lz_q && (idx_q != '0) && lead_zero[idx_q];

  bcd_7seg u_dec (
    .bcd_i (digit_sel),
    .seg_o (digit_seg)
  );

  assign ready  = !pend_valid_q;
  assign accept = load && !pend_valid_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pend_data_d  = pend_data_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = pend_valid_q;
    disp_data_d  = disp_data_q;
    disp_lz_d    = disp_lz_q;

    // A copy out of pend (below) only happens while pend_valid_q is set, and
    // accept needs it clear, so the two never collide on one edge.
    if (accept) begin
      pend_data_d  = data_in;
      pend_lz_d    = lz_en;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          state_d      = ON;
          idx_d        = '0;
          cnt_d        = '0;
          disp_data_d  = pend_data_q;
          disp_lz_d    = pend_lz_q;
          pend_valid_d = 1'b0;
        end
      end

      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ON;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            // Frame boundary: the only point where the shown data may change.
            idx_d = '0;
            if (pend_valid_q) begin
              disp_data_d  = pend_data_q;
              disp_lz_d    = pend_lz_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Pin values are derived from the current state register, so the pins trail
  // the FSM by exactly one clock.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (state_q == ON && !digit_blank) begin
      an_d[idx_q] = 1'b0;
      seg_d       = digit_seg;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only; the
  // combinational blocks above use blocking ones. Mixing them lets the
  // simulator's evaluation order leak into the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      // NOTE: the data registers are cleared as well; they are few bits and a
      // defined value keeps the pins and the digit mux free of X after reset.
      pend_data_q  <= '0;
      pend_lz_q    <= 1'b0;
      disp_data_q  <= '0;
      disp_lz_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_lz_q    <= pend_lz_d;
      disp_data_q  <= disp_data_d;
      disp_lz_q    <= disp_lz_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule : seg7_scan_ctrl

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Self-checking bench for seg7_scan_ctrl with NUM_DIGITS=4, ON_CYCLES=3,
//   GAP_CYCLES=1. A timeline model (cycles since scan start, modulo the frame
//   period) predicts ready/an/seg and is compared every cycle; directed
//   literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int ND     = 4;
  localparam int ONC    = 3;
  localparam int GAPC   = 1;
  localparam int SLOT   = ONC + GAPC;
  localparam int PERIOD = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic        lz_en = 1'b0;
  logic        ready;
  logic [0:6]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .ON_CYCLES  (ONC),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data_in (data_in),
    .lz_en   (lz_en),
    .ready   (ready),
    .seg     (seg),
    .an      (an)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic logic [0:6] m_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b1100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0001100;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic bit m_blank(input logic [15:0] v, input bit lz, input int k);
    if (!lz || k == 0) return 1'b0;
    for (int j = ND - 1; j >= k; j--) begin
      if (v[4*j +: 4] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  bit          m_ok = 1'b0;
  bit          m_scan = 1'b0;
  bit          m_pv = 1'b0;
  int          m_t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_dlz = 1'b0;
  bit          m_plz = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic [0:6]  m_seg = 7'b1111111;
  int          m_pos, m_k;
  bit          m_acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok   = 1'b1;
      m_scan = 1'b0;
      m_pv   = 1'b0;
      m_t    = 0;
      m_disp = '0;
      m_dlz  = 1'b0;
      m_pend = '0;
      m_plz  = 1'b0;
      m_an   = 4'hF;
      m_seg  = 7'b1111111;
    end else if (m_ok) begin
      // Pins after this edge reflect the scan position before it.
      m_an  = 4'hF;
      m_seg = 7'b1111111;
      if (m_scan) begin
        m_pos = m_t % PERIOD;
        m_k   = m_pos / SLOT;
        if ((m_pos % SLOT) < ONC && !m_blank(m_disp, m_dlz, m_k)) begin
          m_an[m_k] = 1'b0;
          m_seg     = m_dec(m_disp[4*m_k +: 4]);
        end
      end
      m_acc = load && !m_pv;
      if (!m_scan) begin
        if (m_pv) begin
          m_scan = 1'b1;
          m_t    = 0;
          m_disp = m_pend;
          m_dlz  = m_plz;
          m_pv   = 1'b0;
        end
      end else begin
        m_t++;
        if ((m_t % PERIOD) == 0 && m_pv) begin
          m_disp = m_pend;
          m_dlz  = m_plz;
          m_pv   = 1'b0;
        end
      end
      if (m_acc) begin
        m_pend = data_in;
        m_plz  = lz_en;
        m_pv   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("ready", ready, !m_pv);
      check("an", an, m_an);
      check("seg", seg, m_seg);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [15:0] d, input logic lz);
    data_in = d;
    lz_en   = lz;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    @(negedge clk);
    while (an !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, an, target);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, ready, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int run_len;
  int bad;
  int lit;

  initial begin
    // Reset held for three edges.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    repeat (100) @(negedge clk);
    check("idle_ready", ready, 1'b1);
    check("idle_an", an, 4'b1111);

    // First load from IDLE: an[0] low two edges after the accept edge.
    do_load(16'h1234, 1'b0);
    @(negedge clk);
    check("acc_ready_low", ready, 1'b0);
    check("acc_an_n1", an, 4'b1111);
    @(negedge clk);
    check("acc_an_n2", an, 4'b1111);
    @(negedge clk);
    check("first_lit_an", an, 4'b1110);
    check("d0_is_4", seg, 7'b1001100);
    run_len = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an === 4'b1110) run_len++;
      else break;
    end
    check("on_len", run_len, ONC);
    check("gap_after_d0", an, 4'b1111);
    wait_an(4'b1101, "d1_an");
    check("d1_is_3", seg, 7'b0000110);
    wait_an(4'b1011, "d2_an");
    check("d2_is_2", seg, 7'b0010010);
    wait_an(4'b0111, "d3_an");
    check("d3_is_1", seg, 7'b1001111);

    // Tear-free update mid-frame, plus an ignored load while not ready.
    wait_an(4'b1101, "tf_mid_an");
    do_load(16'h5678, 1'b0);
    @(negedge clk);
    check("tf_ready_low", ready, 1'b0);
    do_load(16'h9999, 1'b0);
    wait_ready("tf_ready_rise");
    check("tf_ready_rise_pins_off", an, 4'b1111);
    @(negedge clk);
    check("tf_new_d0_an", an, 4'b1110);
    check("tf_new_d0_is_8", seg, 7'b0000000);
    wait_an(4'b0111, "tf_d3_an");
    check("tf_d3_is_5", seg, 7'b0100100);

    // Leading-zero suppression.
    do_load(16'h0070, 1'b1);
    wait_ready("lz_ready");
    @(negedge clk);
    @(negedge clk);
    check("lz_d0_an", an, 4'b1110);
    check("lz_d0_is_0", seg, 7'b0000001);
    wait_an(4'b1101, "lz_d1_an");
    check("lz_d1_is_7", seg, 7'b0001111);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (an === 4'b1011 || an === 4'b0111) bad++;
    end
    check("lz_hi_blanked", bad, 0);

    // All zero with suppression: only digit 0 lights, showing "0".
    do_load(16'h0000, 1'b1);
    wait_ready("zero_ready");
    bad = 0;
    lit = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (an === 4'b1110) begin
        lit++;
        if (seg !== 7'b0000001) bad++;
      end else if (an !== 4'b1111) begin
        bad++;
      end
    end
    check("zero_only_d0", bad, 0);
    check("zero_lit_cycles", lit, 2 * ONC);

    // Non-BCD code shows a dash; zeros without suppression still light.
    do_load(16'h00B0, 1'b0);
    wait_ready("inv_ready");
    wait_an(4'b1101, "inv_d1_an");
    check("inv_d1_dash", seg, 7'b1111110);
    wait_an(4'b0111, "inv_d3_an");
    check("inv_d3_is_0", seg, 7'b0000001);

    // Reset during the digit 2 ON slot.
    wait_an(4'b1011, "mid_d2_an");
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_ready", ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an !== 4'b1111 || ready !== 1'b1) bad++;
    end
    check("post_rst_blank", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl
